// File: rtl/drum_seq_ctrl.sv
// drum_seq_ctrl: load/playback control FSM for the 4-instrument, STEPS-step drum datapath.
// Optional DRUM_SEQ_SYNC_EN adds 2-flop synchronizers on go, pause and slow_clk.
`default_nettype none

module drum_seq_ctrl #(
  parameter int STEPS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       pause,
  input  logic       slow_clk,
  output logic       ld_bpm,
  output logic       ld_ins1,
  output logic       ld_ins2,
  output logic       ld_ins3,
  output logic       ld_ins4,
  output logic       play,
  output logic [3:0] timing,
  output logic       bar_done,
  output logic [2:0] state
);

  localparam logic [3:0] STEPS_W = 4'(STEPS);

  typedef enum logic [2:0] {
    S_LOAD_BPM  = 3'd0,
    S_LOAD_INS1 = 3'd1,
    S_LOAD_INS2 = 3'd2,
    S_LOAD_INS3 = 3'd3,
    S_LOAD_INS4 = 3'd4,
    S_PLAY      = 3'd5
  } state_t;

  logic go_s;
  logic pause_s;
  logic slow_s;

`ifdef DRUM_SEQ_SYNC_EN
  logic [1:0] go_sync_q;
  logic [1:0] pause_sync_q;
  logic [1:0] slow_sync_q;

  // go path resets high so a button held through reset is not seen as a press
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      go_sync_q    <= 2'b11;
      pause_sync_q <= 2'b00;
      slow_sync_q  <= 2'b00;
    end else begin
      go_sync_q    <= {go_sync_q[0], go};
      pause_sync_q <= {pause_sync_q[0], pause};
      slow_sync_q  <= {slow_sync_q[0], slow_clk};
    end
  end

  assign go_s    = go_sync_q[1];
  assign pause_s = pause_sync_q[1];
  assign slow_s  = slow_sync_q[1];
`else
  assign go_s    = go;
  assign pause_s = pause;
  assign slow_s  = slow_clk;
`endif

  logic go_d1_q;
  logic go_d2_q;
  logic beat_d1_q;
  logic beat_d2_q;
  logic go_rise;
  logic beat_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      go_d1_q   <= 1'b1;
      go_d2_q   <= 1'b1;
      beat_d1_q <= 1'b0;
      beat_d2_q <= 1'b0;
    end else begin
      go_d1_q   <= go_s;
      go_d2_q   <= go_d1_q;
      beat_d1_q <= slow_s;
      beat_d2_q <= beat_d1_q;
    end
  end

  assign go_rise   = go_d1_q & ~go_d2_q;
  assign beat_rise = beat_d1_q & ~beat_d2_q;

  state_t     state_q, state_d;
  logic [4:0] ld_q, ld_d;
  logic       play_q, play_d;
  logic [3:0] timing_q, timing_d;
  logic       bar_done_q, bar_done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_LOAD_BPM;
      ld_q       <= 5'b00000;
      play_q     <= 1'b0;
      timing_q   <= 4'd0;
      bar_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_q       <= ld_d;
      play_q     <= play_d;
      timing_q   <= timing_d;
      bar_done_q <= bar_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ld_d       = 5'b00000;
    timing_d   = 4'd0;
    bar_done_d = 1'b0;

    case (state_q)
      S_LOAD_BPM: begin
        if (go_rise) begin
          ld_d[0] = 1'b1;
          state_d = S_LOAD_INS1;
        end
      end
      S_LOAD_INS1: begin
        if (go_rise) begin
          ld_d[1] = 1'b1;
          state_d = S_LOAD_INS2;
        end
      end
      S_LOAD_INS2: begin
        if (go_rise) begin
          ld_d[2] = 1'b1;
          state_d = S_LOAD_INS3;
        end
      end
      S_LOAD_INS3: begin
        if (go_rise) begin
          ld_d[3] = 1'b1;
          state_d = S_LOAD_INS4;
        end
      end
      S_LOAD_INS4: begin
        if (go_rise) begin
          ld_d[4]  = 1'b1;
          state_d  = S_PLAY;
          timing_d = 4'd1;
        end
      end
      S_PLAY: begin
        timing_d = timing_q;
        // go has priority over a coincident beat: leave without stepping
        if (go_rise) begin
          state_d  = S_LOAD_BPM;
          timing_d = 4'd0;
        end else if (!pause_s && beat_rise) begin
          if (timing_q == STEPS_W) begin
            timing_d   = 4'd1;
            bar_done_d = 1'b1;
          end else begin
            timing_d = timing_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_LOAD_BPM;
      end
    endcase

    play_d = (state_d == S_PLAY) && !pause_s;
  end

  assign ld_bpm   = ld_q[0];
  assign ld_ins1  = ld_q[1];
  assign ld_ins2  = ld_q[2];
  assign ld_ins3  = ld_q[3];
  assign ld_ins4  = ld_q[4];
  assign play     = play_q;
  assign timing   = timing_q;
  assign bar_done = bar_done_q;
  assign state    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_drum_seq_ctrl.sv
// Directed self-checking bench for drum_seq_ctrl (STEPS = 8).
`default_nettype none

module tb_drum_seq_ctrl;

`ifdef DRUM_SEQ_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT = 2 + EXTRA;

  logic       clk = 1'b0;
  logic       reset;
  logic       go;
  logic       pause;
  logic       slow_clk;
  logic       ld_bpm, ld_ins1, ld_ins2, ld_ins3, ld_ins4;
  logic       play;
  logic [3:0] timing;
  logic       bar_done;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  wire [4:0] strb = {ld_ins4, ld_ins3, ld_ins2, ld_ins1, ld_bpm};

  drum_seq_ctrl #(.STEPS(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .pause    (pause),
    .slow_clk (slow_clk),
    .ld_bpm   (ld_bpm),
    .ld_ins1  (ld_ins1),
    .ld_ins2  (ld_ins2),
    .ld_ins3  (ld_ins3),
    .ld_ins4  (ld_ins4),
    .play     (play),
    .timing   (timing),
    .bar_done (bar_done),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    go = 1'b1;
    repeat (LAT + 1) tick();
    go = 1'b0;
    repeat (LAT + 1) tick();
  endtask

  task automatic beat_pulse();
    slow_clk = 1'b1;
    repeat (LAT) tick();
    slow_clk = 1'b0;
    repeat (EXTRA + 2) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; go = 1'b0; pause = 1'b0; slow_clk = 1'b0;
    #3;
    checks++; if (strb !== 5'b0) begin errors++; $display("FAIL reset_strobes got %b want 00000", strb); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (timing !== 4'd0) begin errors++; $display("FAIL reset_timing got %0d want 0", timing); end
    checks++; if (play !== 1'b0 || bar_done !== 1'b0) begin errors++; $display("FAIL reset_play_bar got %b%b want 00", play, bar_done); end
    tick();
    reset = 1'b1;
    repeat (LAT + 2) tick();
    checks++; if (state !== 3'd0 || strb !== 5'b0) begin errors++; $display("FAIL idle_after_reset state %0d strb %b want 0 00000", state, strb); end
  endtask

  task automatic test_load_sequence();
    for (int i = 0; i < 5; i++) begin
      go = 1'b1;
      repeat (LAT - 1) tick();
      checks++; if (strb !== 5'b0 || state !== 3'(i)) begin errors++; $display("FAIL load_early%0d strb %b state %0d want 00000 %0d", i, strb, state, i); end
      tick();
      checks++; if (strb !== 5'(1 << i)) begin errors++; $display("FAIL load_strobe%0d got %b want %b", i, strb, 5'(1 << i)); end
      checks++; if (state !== 3'(i + 1)) begin errors++; $display("FAIL load_state%0d got %0d want %0d", i, state, i + 1); end
      tick();
      checks++; if (strb !== 5'b0) begin errors++; $display("FAIL load_strobe_clear%0d got %b want 00000", i, strb); end
      go = 1'b0;
      repeat (LAT + 1) tick();
    end
    checks++; if (timing !== 4'd1) begin errors++; $display("FAIL play_entry_timing got %0d want 1", timing); end
    checks++; if (play !== 1'b1 || state !== 3'd5) begin errors++; $display("FAIL play_entry play %b state %0d want 1 5", play, state); end
  endtask

  task automatic test_beats();
    int prev_t;
    int exp_t;
    prev_t = 1;
    for (int k = 0; k < 9; k++) begin
      exp_t = (prev_t == 8) ? 1 : prev_t + 1;
      slow_clk = 1'b1;
      repeat (LAT - 1) tick();
      checks++; if (timing !== 4'(prev_t)) begin errors++; $display("FAIL beat_early%0d got %0d want %0d", k, timing, prev_t); end
      tick();
      checks++; if (timing !== 4'(exp_t)) begin errors++; $display("FAIL beat_timing%0d got %0d want %0d", k, timing, exp_t); end
      checks++; if (bar_done !== (exp_t == 1)) begin errors++; $display("FAIL beat_bar_done%0d got %b want %b", k, bar_done, exp_t == 1); end
      slow_clk = 1'b0;
      tick();
      checks++; if (bar_done !== 1'b0) begin errors++; $display("FAIL bar_done_width%0d got %b want 0", k, bar_done); end
      repeat (EXTRA + 1) tick();
      prev_t = exp_t;
    end
  endtask

  task automatic test_pause();
    beat_pulse();
    beat_pulse();
    checks++; if (timing !== 4'd4) begin errors++; $display("FAIL pause_setup got %0d want 4", timing); end
    pause = 1'b1;
    repeat (1 + EXTRA) tick();
    checks++; if (play !== 1'b0) begin errors++; $display("FAIL pause_play_low got %b want 0", play); end
    for (int k = 0; k < 3; k++) begin
      beat_pulse();
      checks++; if (timing !== 4'd4 || play !== 1'b0) begin errors++; $display("FAIL pause_hold%0d timing %0d play %b want 4 0", k, timing, play); end
    end
    pause = 1'b0;
    repeat (1 + EXTRA) tick();
    checks++; if (play !== 1'b1 || timing !== 4'd4) begin errors++; $display("FAIL pause_release play %b timing %0d want 1 4", play, timing); end
    beat_pulse();
    checks++; if (timing !== 4'd5) begin errors++; $display("FAIL pause_resume got %0d want 5", timing); end
  endtask

  task automatic test_go_beat_collision();
    repeat (3) beat_pulse();
    checks++; if (timing !== 4'd8) begin errors++; $display("FAIL collide_setup got %0d want 8", timing); end
    go = 1'b1;
    slow_clk = 1'b1;
    repeat (LAT) tick();
    checks++; if (state !== 3'd0 || timing !== 4'd0) begin errors++; $display("FAIL collide_exit state %0d timing %0d want 0 0", state, timing); end
    checks++; if (bar_done !== 1'b0 || strb !== 5'b0 || play !== 1'b0) begin errors++; $display("FAIL collide_outputs bar %b strb %b play %b want 0 00000 0", bar_done, strb, play); end
    tick();
    checks++; if (bar_done !== 1'b0 || strb !== 5'b0) begin errors++; $display("FAIL collide_after bar %b strb %b want 0 00000", bar_done, strb); end
    go = 1'b0;
    slow_clk = 1'b0;
    repeat (LAT + 1) tick();
  endtask

  task automatic test_go_held_and_async_reset();
    int seen;
    seen = 0;
    reset = 1'b0;
    go = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    repeat (6) begin
      tick();
      if (ld_bpm === 1'b1) seen++;
    end
    checks++; if (seen !== 0 || state !== 3'd0) begin errors++; $display("FAIL held_go ld_bpm seen %0d state %0d want 0 0", seen, state); end
    go = 1'b0;
    repeat (LAT + 1) tick();
    go = 1'b1;
    repeat (LAT) tick();
    checks++; if (ld_bpm !== 1'b1 || state !== 3'd1) begin errors++; $display("FAIL repress ld_bpm %b state %0d want 1 1", ld_bpm, state); end
    go = 1'b0;
    repeat (LAT + 1) tick();
    press();
    press();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL reach_ins3 got %0d want 3", state); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL async_reset_state got %0d want 0", state); end
    checks++; if (strb !== 5'b0 || timing !== 4'd0 || play !== 1'b0 || bar_done !== 1'b0) begin errors++; $display("FAIL async_reset_outputs strb %b timing %0d play %b bar %b want zeros", strb, timing, play, bar_done); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_sequence();
    test_beats();
    test_pause();
    test_go_beat_collision();
    test_go_held_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
